fifo_stim_gen: RTL and testbench
================================

# fifo_stim_gen

Synthesizable, parametrised stimulus generator for FIFO verification. It drives a FIFO DUT's `data_in`, `wr_en`, `rd_en` and `rst_n` from on-chip LFSRs, with programmable write, read and reset probabilities and four traffic modes. It counts issued transactions and raises `test_finished` after a fixed number. It replaces the behavioural random driver loop and works unchanged in simulation, emulation and FPGA bring-up.

## Interface
- `DATA_WIDTH`, 16: width of `data_in`, range 1..32.
- `NUM_TXN`, 100000: transactions per run, must be ≥1.
- `RST_CYCLES`, 1: cycles the DUT is held in reset at run start, must be ≥1.
- `WR_ON_PCT`, 70: random-mode `wr_en` probability, percent (0..100).
- `RD_ON_PCT`, 30: random-mode `rd_en` probability, percent (0..100).
- `RST_ON_PCT`, 2: random-mode probability that `fifo_rst_n` is asserted low, percent (0..100).
- `LFSR_SEED`, 32'hACE1_2468: control LFSR seed. Must not be 0 or 32'hFFFF_FFFF.
- `CNT_W`, $clog2(`NUM_TXN`+1): derived width of `txn_cnt`.

Ports:
- `clk`, in, 1: single clock; all state updates on the rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `start`, in, 1: begins a run; honoured in IDLE and DONE only.
- `mode`, in, 2: 00 random, 01 fill (wr only), 10 drain (rd only), 11 concurrent (wr+rd).
- `hold`, in, 1: pauses issue during RUN.
- `data_in`, out, `DATA_WIDTH`: FIFO write data.
- `wr_en`, out, 1: FIFO write enable.
- `rd_en`, out, 1: FIFO read enable.
- `fifo_rst_n`, out, 1: DUT reset, active-low.
- `busy`, out, 1: high in RST_PH and RUN.
- `txn_cnt`, out, `CNT_W`: transactions issued this run.
- `test_finished`, out, 1: sticky high in DONE.

## Operation
- FSM states are IDLE, RST_PH, RUN and DONE. All outputs are registered.
- Reset (async, `rst_n`=0): state IDLE; all outputs 0, including `fifo_rst_n`=0. LFSRs load their seeds: control = `LFSR_SEED`, data = ~`LFSR_SEED`.
- IDLE: `fifo_rst_n`=1, `wr_en`/`rd_en`=0. On `start`=1, go to RST_PH, reseed both LFSRs and clear `txn_cnt`.
- RST_PH: `fifo_rst_n`=0, `wr_en`/`rd_en`=0, `data_in`=0. Lasts exactly `RST_CYCLES` cycles, then go to RUN. It is not counted as a transaction.
- RUN, `hold`=0: one transaction per cycle. `txn_cnt`+1; both LFSRs advance one step. Outputs are taken from the pre-advance LFSR values.
  - Random mode: let c be the control LFSR and TH(p) = (p×128)/100 as an 8-bit elaboration constant.
    - `wr_en` = c[6:0] < TH(`WR_ON_PCT`).
    - `rd_en` = c[13:7] < TH(`RD_ON_PCT`).
    - `fifo_rst_n` = !(c[20:14] < TH(`RST_ON_PCT`)).
    - An in-run DUT reset still drives `wr_en`/`rd_en` normally.
  - Fill, drain and concurrent modes: `fifo_rst_n`=1 and the fixed enables for the mode. LFSRs still advance, so `data_in` is independent of mode.
  - `data_in` = data LFSR[`DATA_WIDTH`-1:0] in every mode.
- RUN, `hold`=1: `wr_en`/`rd_en`=0, `fifo_rst_n`=1, `data_in` unchanged. Counter and LFSRs are frozen.
- `mode` is sampled every RUN cycle.
- When a transaction edge sets `txn_cnt` to `NUM_TXN`, the next edge enters DONE.
- DONE: `wr_en`/`rd_en`=0, `fifo_rst_n`=1, `test_finished`=1, `txn_cnt` held. `start` restarts the run: go to RST_PH, clear `test_finished`, reseed, clear the count.
- `start` is ignored in RST_PH and RUN.
- LFSR step (both LFSRs, 32-bit Galois): next = (v>>1) ^ (v[0] ? 32'h8020_0003 : 0).

## Timing
- `start` is sampled at edge t. `fifo_rst_n` is low from edge t through edge t+`RST_CYCLES`−1.
- The first transaction is visible after edge t+`RST_CYCLES`, with `txn_cnt`=1.
- Each transaction is visible for exactly one cycle when no `hold` intervenes.
- Run length without `hold`: `RST_CYCLES`+`NUM_TXN` cycles of `busy`, then `test_finished` rises on the following edge.
- `hold` takes effect at the edge sampling it. Latency is 0 cycles to pause and 0 cycles to resume.
- `rst_n` mid-run: outputs drop to reset values immediately (asynchronously). Release enters IDLE; the next run reproduces the first run bit-for-bit.
- Boundaries:
  - PCT=100 gives an always-true comparison (threshold 128).
  - PCT=0 gives never.
  - `NUM_TXN`=1 issues one transaction, then DONE.

## Test plan
- Parameters: `NUM_TXN`=8, `RST_CYCLES`=2, `DATA_WIDTH`=8, unless stated.
- Reset: hold `rst_n`=0 → all outputs 0. Release, one edge → `fifo_rst_n`=1, `busy`=0.
- Fill mode (`mode`=01), pulse `start` → `fifo_rst_n`=0 for 2 cycles. Then 8 cycles of `wr_en`=1, `rd_en`=0, `txn_cnt` 1..8. Next edge → `test_finished`=1, `wr_en`=0.
- Random mode with `WR_ON_PCT`=100, `RD_ON_PCT`=0, `RST_ON_PCT`=0 → `wr_en`=1 and `rd_en`=0 every cycle, `fifo_rst_n`=1. `data_in` matches a bench LFSR model seeded with 32'h531E_DB97 (low 8 bits), step for step.
- `hold`=1 during RUN transactions 3–5 → `wr_en`/`rd_en`=0, `txn_cnt` frozen at 2. After release, `data_in` continues with the sequence value that would have been transaction 3.
- Assert `rst_n`=0 at `txn_cnt`=4 → outputs 0 within the same cycle. Restart → the `data_in`/`wr_en`/`rd_en` sequence is identical to the first run.
- `start` pulsed during RUN → ignored, count unaffected. `start` in DONE → `test_finished` clears on that edge and RST_PH begins.

Source files
------------

// File: rtl/fifo_stim_gen.sv
// LFSR-driven stimulus generator for FIFO verification: produces write data, write/read
// enables and an active-low FIFO reset with programmable probabilities and four traffic modes.
module fifo_stim_gen #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned NUM_TXN    = 100000,
  parameter int unsigned RST_CYCLES = 1,
  parameter int unsigned WR_ON_PCT  = 70,
  parameter int unsigned RD_ON_PCT  = 30,
  parameter int unsigned RST_ON_PCT = 2,
  parameter logic [31:0] LFSR_SEED  = 32'hACE1_2468,
  parameter int unsigned CNT_W      = $clog2(NUM_TXN + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            mode,
  input  logic                  hold,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  wr_en,
  output logic                  rd_en,
  output logic                  fifo_rst_n,
  output logic                  busy,
  output logic [CNT_W-1:0]      txn_cnt,
  output logic                  test_finished
);

  localparam logic [7:0]       WR_TH     = 8'((WR_ON_PCT * 128) / 100);
  localparam logic [7:0]       RD_TH     = 8'((RD_ON_PCT * 128) / 100);
  localparam logic [7:0]       RST_TH    = 8'((RST_ON_PCT * 128) / 100);
  localparam int unsigned      PH_W      = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [PH_W-1:0]  PH_LAST   = PH_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_END   = CNT_W'(NUM_TXN);
  localparam logic [31:0]      LFSR_POLY = 32'h8020_0003;

  localparam logic [1:0] MODE_RANDOM = 2'b00;
  localparam logic [1:0] MODE_FILL   = 2'b01;
  localparam logic [1:0] MODE_DRAIN  = 2'b10;

  typedef enum logic [1:0] {IDLE, RST_PH, RUN, DONE} state_t;

  state_t                  state_reg, state_next;
  logic [PH_W-1:0]         ph_cnt_reg, ph_cnt_next;
  logic [CNT_W-1:0]        txn_cnt_reg, txn_cnt_next;
  logic [31:0]             ctrl_lfsr_reg, ctrl_lfsr_next;
  logic [31:0]             data_lfsr_reg, data_lfsr_next;
  logic [DATA_WIDTH-1:0]   data_in_reg, data_in_next;
  logic                    wr_en_reg, wr_en_next;
  logic                    rd_en_reg, rd_en_next;
  logic                    fifo_rst_n_reg, fifo_rst_n_next;
  logic                    busy_reg, busy_next;
  logic                    test_finished_reg, test_finished_next;
  logic                    issue;
  logic                    reseed;
  logic                    rnd_wr, rnd_rd, rnd_rst;

  function automatic logic [31:0] lfsr_step(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? LFSR_POLY : 32'h0);
  endfunction

  // 7-bit random fields against 8-bit thresholds so that 100 % (128) is always true
  assign rnd_wr  = {1'b0, ctrl_lfsr_reg[6:0]}   < WR_TH;
  assign rnd_rd  = {1'b0, ctrl_lfsr_reg[13:7]}  < RD_TH;
  assign rnd_rst = {1'b0, ctrl_lfsr_reg[20:14]} < RST_TH;

  always_comb begin
    state_next         = state_reg;
    ph_cnt_next        = ph_cnt_reg;
    txn_cnt_next       = txn_cnt_reg;
    data_in_next       = data_in_reg;
    wr_en_next         = 1'b0;
    rd_en_next         = 1'b0;
    fifo_rst_n_next    = 1'b1;
    busy_next          = 1'b0;
    test_finished_next = 1'b0;
    issue              = 1'b0;
    reseed             = 1'b0;

    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          state_next      = RST_PH;
          ph_cnt_next     = '0;
          txn_cnt_next    = '0;
          data_in_next    = '0;
          fifo_rst_n_next = 1'b0;
          busy_next       = 1'b1;
          reseed          = 1'b1;
        end else begin
          test_finished_next = (state_reg == DONE);
        end
      end
      RST_PH: begin
        busy_next    = 1'b1;
        data_in_next = '0;
        if (ph_cnt_reg == PH_LAST) begin
          // The edge leaving reset already carries the first transaction
          state_next = RUN;
          issue      = !hold;
        end else begin
          ph_cnt_next     = ph_cnt_reg + PH_W'(1);
          fifo_rst_n_next = 1'b0;
        end
      end
      RUN: begin
        if (txn_cnt_reg == CNT_END) begin
          state_next         = DONE;
          test_finished_next = 1'b1;
        end else begin
          busy_next = 1'b1;
          issue     = !hold;
        end
      end
      default: state_next = IDLE;
    endcase

    if (issue) begin
      txn_cnt_next = txn_cnt_reg + CNT_W'(1);
      data_in_next = data_lfsr_reg[DATA_WIDTH-1:0];
      case (mode)
        MODE_RANDOM: begin
          wr_en_next      = rnd_wr;
          rd_en_next      = rnd_rd;
          fifo_rst_n_next = !rnd_rst;
        end
        MODE_FILL:  wr_en_next = 1'b1;
        MODE_DRAIN: rd_en_next = 1'b1;
        default: begin
          wr_en_next = 1'b1;
          rd_en_next = 1'b1;
        end
      endcase
    end

    ctrl_lfsr_next = reseed ? LFSR_SEED  : (issue ? lfsr_step(ctrl_lfsr_reg) : ctrl_lfsr_reg);
    data_lfsr_next = reseed ? ~LFSR_SEED : (issue ? lfsr_step(data_lfsr_reg) : data_lfsr_reg);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg         <= IDLE;
      ph_cnt_reg        <= '0;
      txn_cnt_reg       <= '0;
      ctrl_lfsr_reg     <= LFSR_SEED;
      data_lfsr_reg     <= ~LFSR_SEED;
      data_in_reg       <= '0;
      wr_en_reg         <= 1'b0;
      rd_en_reg         <= 1'b0;
      fifo_rst_n_reg    <= 1'b0;
      busy_reg          <= 1'b0;
      test_finished_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      ph_cnt_reg        <= ph_cnt_next;
      txn_cnt_reg       <= txn_cnt_next;
      ctrl_lfsr_reg     <= ctrl_lfsr_next;
      data_lfsr_reg     <= data_lfsr_next;
      data_in_reg       <= data_in_next;
      wr_en_reg         <= wr_en_next;
      rd_en_reg         <= rd_en_next;
      fifo_rst_n_reg    <= fifo_rst_n_next;
      busy_reg          <= busy_next;
      test_finished_reg <= test_finished_next;
    end
  end

  assign data_in       = data_in_reg;
  assign wr_en         = wr_en_reg;
  assign rd_en         = rd_en_reg;
  assign fifo_rst_n    = fifo_rst_n_reg;
  assign busy          = busy_reg;
  assign txn_cnt       = txn_cnt_reg;
  assign test_finished = test_finished_reg;

endmodule

// File: tb/tb_fifo_stim_gen.sv
// Bench for fifo_stim_gen: two differently parameterised instances share random stimulus and
// are checked every cycle against a timeline model, plus hand-computed sequence checkpoints.
module tb_fifo_stim_gen;

  localparam int S_IDLE = 0;
  localparam int S_RST  = 1;
  localparam int S_RUN  = 2;
  localparam int S_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       hold = 1'b0;

  logic [7:0]  a_data;
  logic        a_wr, a_rd, a_frst, a_busy, a_tf;
  logic [3:0]  a_cnt;
  logic [11:0] b_data;
  logic        b_wr, b_rd, b_frst, b_busy, b_tf;
  logic [2:0]  b_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  fifo_stim_gen #(
    .DATA_WIDTH(8), .NUM_TXN(8), .RST_CYCLES(2),
    .WR_ON_PCT(100), .RD_ON_PCT(0), .RST_ON_PCT(0)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hold(hold),
    .data_in(a_data), .wr_en(a_wr), .rd_en(a_rd), .fifo_rst_n(a_frst),
    .busy(a_busy), .txn_cnt(a_cnt), .test_finished(a_tf)
  );

  fifo_stim_gen #(
    .DATA_WIDTH(12), .NUM_TXN(5), .RST_CYCLES(1),
    .WR_ON_PCT(50), .RD_ON_PCT(30), .RST_ON_PCT(20), .LFSR_SEED(32'h0F0F_1357)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .mode(mode), .hold(hold),
    .data_in(b_data), .wr_en(b_wr), .rd_en(b_rd), .fifo_rst_n(b_frst),
    .busy(b_busy), .txn_cnt(b_cnt), .test_finished(b_tf)
  );

  always #5 clk = ~clk;

  // Per-instance parameters as seen by the model
  int          p_n    [2] = '{8, 5};
  int          p_rc   [2] = '{2, 1};
  int          p_wr   [2] = '{100, 50};
  int          p_rd   [2] = '{0, 30};
  int          p_rst  [2] = '{0, 20};
  logic [31:0] p_seed [2] = '{32'hACE1_2468, 32'h0F0F_1357};
  logic [31:0] p_mask [2] = '{32'h0000_00FF, 32'h0000_0FFF};

  int          m_ph  [2];
  int          m_k   [2];
  int          m_cnt [2];
  logic [31:0] m_c   [2];
  logic [31:0] m_d   [2];
  logic [31:0] e_data [2];
  bit          e_wr [2], e_rd [2], e_frst [2], e_busy [2], e_tf [2];

  logic [7:0] lit [6] = '{8'h97, 8'hC8, 8'hE4, 8'h72, 8'hB9, 8'hDF};

  function automatic logic [31:0] lfsr(input logic [31:0] v);
    return (v >> 1) ^ (v[0] ? 32'h8020_0003 : 32'h0);
  endfunction

  function automatic int th(input int p);
    return (p * 128) / 100;
  endfunction

  task automatic model_edge(input int i);
    int c7;
    if (!rst_n) begin
      m_ph[i] = S_IDLE; m_k[i] = 0; m_cnt[i] = 0;
      m_c[i] = p_seed[i]; m_d[i] = ~p_seed[i];
      e_data[i] = 0; e_wr[i] = 0; e_rd[i] = 0; e_frst[i] = 0; e_busy[i] = 0; e_tf[i] = 0;
      return;
    end
    e_wr[i] = 0; e_rd[i] = 0; e_frst[i] = 1;
    if (m_ph[i] == S_IDLE || m_ph[i] == S_DONE) begin
      if (start) begin
        m_ph[i] = S_RST; m_k[i] = 1; m_cnt[i] = 0;
        m_c[i] = p_seed[i]; m_d[i] = ~p_seed[i];
        e_data[i] = 0; e_frst[i] = 0; e_busy[i] = 1; e_tf[i] = 0;
      end else begin
        e_busy[i] = 0; e_tf[i] = (m_ph[i] == S_DONE);
      end
    end else if (m_ph[i] == S_RST && m_k[i] < p_rc[i]) begin
      m_k[i]++; e_frst[i] = 0; e_busy[i] = 1;
    end else if (m_ph[i] == S_RUN && m_cnt[i] == p_n[i]) begin
      m_ph[i] = S_DONE; e_busy[i] = 0; e_tf[i] = 1;
    end else begin
      m_ph[i] = S_RUN; e_busy[i] = 1;
      if (!hold) begin
        m_cnt[i]++;
        e_data[i] = m_d[i] & p_mask[i];
        case (mode)
          2'b00: begin
            c7 = int'(m_c[i] % 128);            e_wr[i] = (c7 < th(p_wr[i]));
            c7 = int'((m_c[i] >> 7) % 128);     e_rd[i] = (c7 < th(p_rd[i]));
            c7 = int'((m_c[i] >> 14) % 128);    e_frst[i] = !(c7 < th(p_rst[i]));
          end
          2'b01: e_wr[i] = 1;
          2'b10: e_rd[i] = 1;
          default: begin e_wr[i] = 1; e_rd[i] = 1; end
        endcase
        m_c[i] = lfsr(m_c[i]);
        m_d[i] = lfsr(m_d[i]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_a_cnt(input logic [3:0] target, input int budget);
    int n = 0;
    while (a_cnt != target && n < budget) begin tick(); n++; end
    chk("wait_a_cnt_reached", 32'(a_cnt), 32'(target));
  endtask

  task automatic wait_a_done(input int budget);
    int n = 0;
    while (!a_tf && n < budget) begin tick(); n++; end
    chk("wait_a_done", 32'(a_tf), 32'd1);
  endtask

  // Model follows every edge, and the asynchronous reset the moment it falls
  initial begin
    #1;
    model_edge(0); model_edge(1);
    forever begin
      @(posedge clk or negedge rst_n);
      model_edge(0); model_edge(1);
    end
  end

  logic [3:0] prev_a_cnt = 4'd0;
  initial begin
    forever begin
      @(negedge clk);
      chk("a_data", 32'(a_data), e_data[0]);
      chk("a_wr",   32'(a_wr),   32'(e_wr[0]));
      chk("a_rd",   32'(a_rd),   32'(e_rd[0]));
      chk("a_frst", 32'(a_frst), 32'(e_frst[0]));
      chk("a_busy", 32'(a_busy), 32'(e_busy[0]));
      chk("a_tf",   32'(a_tf),   32'(e_tf[0]));
      chk("a_cnt",  32'(a_cnt),  32'(m_cnt[0]));
      chk("b_data", 32'(b_data), e_data[1]);
      chk("b_wr",   32'(b_wr),   32'(e_wr[1]));
      chk("b_rd",   32'(b_rd),   32'(e_rd[1]));
      chk("b_frst", 32'(b_frst), 32'(e_frst[1]));
      chk("b_busy", 32'(b_busy), 32'(e_busy[1]));
      chk("b_tf",   32'(b_tf),   32'(e_tf[1]));
      chk("b_cnt",  32'(b_cnt),  32'(m_cnt[1]));
      if (a_busy && a_cnt != prev_a_cnt)
        $display("txn A #%0d data=%02h wr=%0b rd=%0b frst=%0b", a_cnt, a_data, a_wr, a_rd, a_frst);
      prev_a_cnt = a_cnt;
    end
  end

  initial begin
    // Reset values, then one edge in IDLE
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_data", 32'(a_data), 32'd0);
    chk("rst_wr",   32'(a_wr),   32'd0);
    chk("rst_frst", 32'(a_frst), 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_cnt",  32'(a_cnt),  32'd0);
    rst_n = 1'b1;
    tick();
    chk("idle_frst", 32'(a_frst), 32'd1);
    chk("idle_busy", 32'(a_busy), 32'd0);

    // Fill run: two reset cycles, eight writes, then DONE
    mode = 2'b01; start = 1'b1;
    tick(); start = 1'b0;
    chk("fill_rst0_frst", 32'(a_frst), 32'd0);
    chk("fill_rst0_busy", 32'(a_busy), 32'd1);
    tick();
    chk("fill_rst1_frst", 32'(a_frst), 32'd0);
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("fill_cnt", 32'(a_cnt), 32'(k));
      chk("fill_wr",  32'(a_wr),  32'd1);
      chk("fill_rd",  32'(a_rd),  32'd0);
      if (k <= 6) chk("fill_data", 32'(a_data), 32'(lit[k-1]));
    end
    tick();
    chk("fill_done_tf", 32'(a_tf), 32'd1);
    chk("fill_done_wr", 32'(a_wr), 32'd0);

    // Random mode restarted from DONE, hold across transactions 3..5
    mode = 2'b00; start = 1'b1;
    tick(); start = 1'b0;
    chk("restart_tf",   32'(a_tf),   32'd0);
    chk("restart_frst", 32'(a_frst), 32'd0);
    tick(); tick(); tick();
    chk("pre_hold_cnt", 32'(a_cnt), 32'd2);
    hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold_cnt",  32'(a_cnt),  32'd2);
      chk("hold_wr",   32'(a_wr),   32'd0);
      chk("hold_data", 32'(a_data), 32'(lit[1]));
    end
    hold = 1'b0;
    tick();
    chk("resume_cnt",  32'(a_cnt),  32'd3);
    chk("resume_data", 32'(a_data), 32'(lit[2]));
    start = 1'b1;
    tick(); start = 1'b0;
    chk("start_in_run_cnt", 32'(a_cnt), 32'd4);
    wait_a_done(30);

    // Mid-run asynchronous reset, then a run that must repeat from the seed
    start = 1'b1;
    tick(); start = 1'b0;
    wait_a_cnt(4'd4, 20);
    rst_n = 1'b0;
    #1;
    chk("async_data", 32'(a_data), 32'd0);
    chk("async_wr",   32'(a_wr),   32'd0);
    chk("async_frst", 32'(a_frst), 32'd0);
    chk("async_cnt",  32'(a_cnt),  32'd0);
    chk("async_b_wr", 32'(b_wr),   32'd0);
    tick(); tick();
    rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick(); start = 1'b0;
    tick();
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("rerun_cnt", 32'(a_cnt), 32'(k));
      chk("rerun_wr",  32'(a_wr),  32'd1);
      chk("rerun_rd",  32'(a_rd),  32'd0);
      if (k <= 6) chk("rerun_data", 32'(a_data), 32'(lit[k-1]));
    end
    tick();
    chk("rerun_tf", 32'(a_tf), 32'd1);

    // Randomised traffic, checked cycle by cycle against the model
    for (int n = 0; n < 600; n++) begin
      tick();
      rst_n = ($urandom_range(0, 99) != 0);
      start = ($urandom_range(0, 9) == 0);
      mode  = 2'($urandom_range(0, 3));
      hold  = ($urandom_range(0, 4) == 0);
    end
    rst_n = 1'b1; start = 1'b0; hold = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
